mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width of storage and data ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, width of the request address.
REQ-003 SHALL have parameter DEPTH, default 256, number of storage words; valid word addresses are 0..DEPTH-1.
REQ-004 SHALL have parameter WAIT_STATES, default 1, range 0..15, number of extra cycles inserted before the response.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req  input  1  requester asserts to start a transfer.
REQ-008 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-009 SHALL have port addr  input  ADDR_WIDTH  word address; sampled with req.
REQ-010 SHALL have port wdata  input  DATA_WIDTH  write data; sampled with req.
REQ-011 SHALL have port ack  output  1  one-cycle response strobe.
REQ-012 SHALL have port rdata  output  DATA_WIDTH  read data; valid only while ack=1.
REQ-013 SHALL have port err  output  1  out-of-range flag; valid only while ack=1.
REQ-014 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP, plus a 4-bit wait counter.
REQ-016 SHALL, in IDLE with req=1 at edge E0, capture we, addr and wdata, then go to WAIT (WAIT_STATES>0, counter loaded with WAIT_STATES-1) or directly to RESP (WAIT_STATES=0).
REQ-017 SHALL, in WAIT, decrement the counter each edge and go to RESP on the edge where the counter reads 0, so RESP is entered at edge E0+WAIT_STATES.
REQ-018 SHALL drive ack, rdata and err as registered outputs: ack=1 for exactly the one cycle spent in RESP.
REQ-019 SHALL always go from RESP to IDLE on the next edge; a transfer occupies WAIT_STATES+1 cycles of busy, and back-to-back throughput is one transfer per WAIT_STATES+2 cycles.
REQ-020 SHALL ignore req, we, addr and wdata while busy=1; captured values are used unchanged for the whole transfer.
REQ-021 SHALL, if req is still high in IDLE after an ack, accept it as a new transfer.
REQ-022 SHALL treat a captured address below DEPTH as in range, and any higher address, including any nonzero bit above the index width, as out of range.
REQ-023 SHALL commit an in-range write to storage at the RESP-entry edge; rdata SHALL be 0 for writes.
REQ-024 SHALL sample storage for an in-range read at the RESP-entry edge, so a read following a write to the same address returns the new data.
REQ-025 SHALL leave storage unchanged for an out-of-range access, drive rdata=0, and assert err=1 together with ack.
REQ-026 SHALL hold err=0 and rdata=0 whenever ack=0.
REQ-027 SHALL drive busy combinationally from the state register (busy = state != IDLE).

Reset
REQ-028 SHALL, on any edge with rst=1, force state=IDLE, counter=0, ack=0, err=0 and rdata=0, regardless of state.
REQ-029 SHALL discard a transfer interrupted by reset before its RESP-entry edge: no write is committed and no ack is issued.
REQ-030 SHALL not alter storage contents on reset; storage is initialised only by writes or by the bench.
REQ-031 SHALL give rst priority over a simultaneous req; a req in the same cycle as rst is not accepted.

Verification
REQ-032 SHALL pass this scenario with WAIT_STATES=1: write 5 to addr 100, then 7 to addr 101, then read both -> each ack occurs 2 cycles after acceptance; rdata=5, then 7; err=0 throughout.
REQ-033 SHALL pass this scenario: write 12 to addr 112, then immediately read addr 112 with req held high -> second ack exactly 3 cycles after the first; rdata=12.
REQ-034 SHALL pass this scenario: write 16'hBEEF to addr 300, then read addr 300 -> ack with err=1 and rdata=0 both times; storage words 0..255 are unchanged (300 mod 256 = 44 untouched).
REQ-035 SHALL pass this scenario: while busy, pulse req with write 9 to addr 100 -> no extra ack, and mem[100] remains 5.
REQ-036 SHALL pass this scenario with WAIT_STATES=3: accept write 99 to addr 101, assert rst in the second WAIT cycle -> ack never rises, busy=0 the cycle after rst, mem[101] remains 7.
REQ-037 SHALL pass this scenario with WAIT_STATES=0: a read of addr 100 -> ack in the cycle immediately after acceptance with rdata=5, and busy high for exactly one cycle.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ack handshake with a programmable
// number of wait states before each one-cycle response.
module mem_responder #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  ack,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  err,
   output logic                  busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
   localparam logic [3:0] CNT_LOAD = 4'(WS_M1);
   // One extra bit so that DEPTH == 2**ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [3:0]              cnt;
   logic                    we_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    accept;
   logic                    resp_entry;
   logic                    acc_we;
   logic [ADDR_WIDTH-1:0]   acc_addr;
   logic [DATA_WIDTH-1:0]   acc_wdata;
   logic                    in_range;
   logic [IDX_W-1:0]        idx;

   assign busy   = (state != IDLE);
   assign accept = (state == IDLE) && req;

   // With zero wait states RESP is entered on the accept edge itself, before
   // the capture registers hold the request, so the access uses live inputs.
   assign acc_we    = (state == IDLE) ? we    : we_q;
   assign acc_addr  = (state == IDLE) ? addr  : addr_q;
   assign acc_wdata = (state == IDLE) ? wdata : wdata_q;
   assign in_range  = ({1'b0, acc_addr} < DEPTH_A);
   assign idx       = acc_addr[IDX_W-1:0];

   // Next-state logic: IDLE -> WAIT/RESP on req, WAIT counts down, RESP lasts one cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
         WAIT:    if (cnt == 4'd0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign resp_entry = (state_nxt == RESP) && (state != RESP);

   // State register; reset wins over any simultaneous request
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Wait counter: loaded on accept, decremented while waiting
   always_ff @(posedge clk) begin
      if (rst)                             cnt <= 4'd0;
      else if (accept)                     cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != 0)  cnt <= cnt - 4'd1;
   end

   // Request capture; held unchanged for the rest of the transfer
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= we;
         addr_q  <= addr;
         wdata_q <= wdata;
      end
   end

   // Storage write at the RESP-entry edge for in-range writes only
   always_ff @(posedge clk) begin
      if (!rst && resp_entry && acc_we && in_range) mem[idx] <= acc_wdata;
   end

   // Registered response: outputs are non-zero only during the RESP cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         ack   <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
      end else if (resp_entry) begin
         ack   <= 1'b1;
         err   <= !in_range;
         rdata <= (!acc_we && in_range) ? mem[idx] : '0;
      end else begin
         ack   <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with 1, 3 and 0 wait
// states driven by directed transfers; a monitor pops expected responses.
module tb_mem_responder;

   localparam int DW = 16;
   localparam int AW = 16;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
      logic [31:0]   cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_v   [3];
   logic          we_v    [3];
   logic [AW-1:0] addr_v  [3];
   logic [DW-1:0] wdata_v [3];
   logic          ack_v   [3];
   logic [DW-1:0] rdata_v [3];
   logic          err_v   [3];
   logic          busy_v  [3];

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit mon_en = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(256), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
      .ack(ack_v[0]), .rdata(rdata_v[0]), .err(err_v[0]), .busy(busy_v[0]));

   mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
      .ack(ack_v[1]), .rdata(rdata_v[1]), .err(err_v[1]), .busy(busy_v[1]));

   mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]), .wdata(wdata_v[2]),
      .ack(ack_v[2]), .rdata(rdata_v[2]), .err(err_v[2]), .busy(busy_v[2]));

   function automatic int ws_of(int k);
      case (k)
         0:       return 1;
         1:       return 3;
         default: return 0;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(int k, exp_t e);
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   function automatic bit pop(int k, output exp_t e);
      bit ok = 0;
      e = '0;
      case (k)
         0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1; end
         1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1; end
      endcase
      return ok;
   endfunction

   // Monitor: every ack must match the head of that instance's queue in
   // cycle, data and error; outside ack, rdata and err must read zero.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < 3; k++) begin
            exp_t e;
            bit   have;
            if (ack_v[k] === 1'b1) begin
               have = pop(k, e);
               if (!have) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_ack[%0d]: got ack=1 with no transfer pending, expected ack=0 (cycle %0d)", k, cyc);
               end else begin
                  check($sformatf("ack_cycle[%0d]", k), 32'(cyc), e.cyc);
                  check($sformatf("rdata[%0d]", k), 32'(rdata_v[k]), 32'(e.rdata));
                  check($sformatf("err[%0d]", k), 32'(err_v[k]), 32'(e.err));
               end
            end else begin
               check($sformatf("idle_outputs[%0d]", k), 32'({ack_v[k], err_v[k], rdata_v[k]}), 32'd0);
            end
         end
      end
   end

   // Issue one transfer once the instance is idle; the expected ack cycle is
   // the accept edge plus the instance's wait states.
   task automatic xfer(int k, bit w, logic [AW-1:0] a, logic [DW-1:0] d,
                       logic [DW-1:0] exp_rd, bit exp_err);
      exp_t e;
      int   guard = 0;
      @(negedge clk);
      while (busy_v[k] !== 1'b0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout[%0d]: busy=%b after 100 cycles, expected 0", k, busy_v[k]);
      end
      req_v[k]   = 1'b1;
      we_v[k]    = w;
      addr_v[k]  = a;
      wdata_v[k] = d;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = 32'(cyc + 1 + ws_of(k));
      push(k, e);
      @(posedge clk);
      #1 req_v[k] = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      n_chk++;
      if (guard >= 200) begin
         n_fail++;
         $display("FAIL drain: %0d responses still pending, expected 0",
                  q0.size() + q1.size() + q2.size());
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_v[k] = 1'b0; we_v[k] = 1'b0; addr_v[k] = '0; wdata_v[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_ack[%0d]", k),   32'(ack_v[k]),   32'd0);
         check($sformatf("reset_busy[%0d]", k),  32'(busy_v[k]),  32'd0);
         check($sformatf("reset_err[%0d]", k),   32'(err_v[k]),   32'd0);
         check($sformatf("reset_rdata[%0d]", k), 32'(rdata_v[k]), 32'd0);
      end
      mon_en = 1'b1;

      // One wait state: basic writes and reads
      xfer(0, 1, 16'd100, 16'd5, 16'd0, 0);
      xfer(0, 1, 16'd101, 16'd7, 16'd0, 0);
      xfer(0, 0, 16'd100, 16'd0, 16'd5, 0);
      xfer(0, 0, 16'd101, 16'd0, 16'd7, 0);

      // Write then read with req held high across the transfers
      @(negedge clk);
      while (busy_v[0] !== 1'b0) @(negedge clk);
      req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 16'd112; wdata_v[0] = 16'd12;
      e.rdata = 16'd0;  e.err = 1'b0; e.cyc = 32'(cyc + 2); push(0, e);
      e.rdata = 16'd12; e.err = 1'b0; e.cyc = 32'(cyc + 5); push(0, e);
      @(posedge clk);
      #1 we_v[0] = 1'b0; wdata_v[0] = 16'd0;
      repeat (3) @(posedge clk);
      #1 req_v[0] = 1'b0;

      // Range boundaries: last word, first out-of-range word, stray high bits
      xfer(0, 1, 16'd44,   16'h4444, 16'd0,    0);
      xfer(0, 1, 16'd300,  16'hBEEF, 16'd0,    1);
      xfer(0, 0, 16'd300,  16'd0,    16'd0,    1);
      xfer(0, 0, 16'd44,   16'd0,    16'h4444, 0);
      xfer(0, 1, 16'd255,  16'h1234, 16'd0,    0);
      xfer(0, 1, 16'd256,  16'hDEAD, 16'd0,    1);
      xfer(0, 0, 16'd255,  16'd0,    16'h1234, 0);
      xfer(0, 1, 16'h8064, 16'h5555, 16'd0,    1);
      xfer(0, 0, 16'd0,    16'd0,    16'd0,    0);
      xfer(0, 0, 16'd100,  16'd0,    16'd5,    0);

      // Request pulsed while busy must be ignored
      xfer(0, 0, 16'd101, 16'd0, 16'd7, 0);
      req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 16'd100; wdata_v[0] = 16'd9;
      @(posedge clk);
      #1 req_v[0] = 1'b0;
      xfer(0, 0, 16'd100, 16'd0, 16'd5, 0);
      drain();

      // Reset takes priority over a simultaneous request
      rst = 1'b1; req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 16'd100; wdata_v[0] = 16'd77;
      @(posedge clk);
      #1 rst = 1'b0; req_v[0] = 1'b0;
      @(negedge clk);
      check("rst_vs_req_busy", 32'(busy_v[0]), 32'd0);
      xfer(0, 0, 16'd100, 16'd0, 16'd5, 0);
      drain();

      // Three wait states: reset during the second WAIT cycle discards the write
      xfer(1, 1, 16'd101, 16'd7, 16'd0, 0);
      xfer(1, 0, 16'd101, 16'd0, 16'd7, 0);
      drain();
      req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 16'd101; wdata_v[1] = 16'd99;
      @(posedge clk);
      #1 req_v[1] = 1'b0;
      @(negedge clk);
      check("ws3_busy_after_accept", 32'(busy_v[1]), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ws3_busy_after_rst", 32'(busy_v[1]), 32'd0);
      check("ws3_ack_after_rst",  32'(ack_v[1]),  32'd0);
      repeat (5) @(negedge clk);
      xfer(1, 0, 16'd101, 16'd0, 16'd7, 0);
      drain();

      // Zero wait states: ack the cycle after accept, busy for one cycle
      xfer(2, 1, 16'd100, 16'd5, 16'd0, 0);
      xfer(2, 0, 16'd100, 16'd0, 16'd5, 0);
      @(negedge clk);
      check("ws0_busy_first", 32'(busy_v[2]), 32'd1);
      @(negedge clk);
      check("ws0_busy_second", 32'(busy_v[2]), 32'd0);
      drain();

      repeat (4) @(negedge clk);
      check("pending_at_end", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
